// File: rtl/xvga_pkg.sv
// XVGA 1024x768@60 timing constants shared by the generator and its users.
// Holds default porch/sync sizes, derived totals, sync windows and count widths.
package xvga_pkg;

    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 160;
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;

    localparam int XGA_H_TOTAL =
        XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
    localparam int XGA_V_TOTAL =
        XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

    localparam int XGA_HSYNC_START = XGA_H_ACTIVE + XGA_H_FP;
    localparam int XGA_HSYNC_END   = XGA_HSYNC_START + XGA_H_SYNC;
    localparam int XGA_VSYNC_START = XGA_V_ACTIVE + XGA_V_FP;
    localparam int XGA_VSYNC_END   = XGA_VSYNC_START + XGA_V_SYNC;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;

    // True when every index 0..total-1 is representable in w bits.
    function automatic bit cnt_fits(input int total, input int w);
        return (total > 0) && (total <= (1 << w));
    endfunction

endpackage

// File: rtl/xvga_timing_gen_if.sv
// Raster timing bundle driven by xvga_timing_gen, read by pixel generators.
// Ports: hcount/vcount, hsync/vsync/blank, line/frame strobes, delayed syncs.
interface xvga_timing_gen_if
    import xvga_pkg::*;
;
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              blank;
    logic              line_start;
    logic              frame_start;
    logic              dhsync;
    logic              dvsync;
    logic              dblank;

    modport master (
        output hcount, vcount, hsync, vsync, blank,
        output line_start, frame_start,
        output dhsync, dvsync, dblank
    );

    modport slave (
        input hcount, vcount, hsync, vsync, blank,
        input line_start, frame_start,
        input dhsync, dvsync, dblank
    );

endinterface

// File: rtl/sync_delay_line.sv
// DELAY-deep shift register for re-aligning sync/blank with pipelined pixels.
// Ports: clk, rst_n (async low), i_d in, o_q = i_d delayed DELAY clocks.
module sync_delay_line #(
    parameter int             W       = 3,
    parameter int             DELAY   = 0,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    if ((DELAY < 0) || (DELAY > 15)) begin : g_bad_delay
        $error("sync_delay_line: DELAY must be 0..15");
    end

    if (DELAY == 0) begin : g_bypass
        // Zero depth: pass-through, clock and reset are not needed.
        logic w_unused;
        assign w_unused = clk ^ rst_n;
        assign o_q      = i_d;
    end else begin : g_shift
        logic [W-1:0] r_sr [DELAY];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DELAY; i++) begin
                    r_sr[i] <= RST_VAL;
                end
            end else begin
                r_sr[0] <= i_d;
                for (int i = 1; i < DELAY; i++) begin
                    r_sr[i] <= r_sr[i-1];
                end
            end
        end

        assign o_q = r_sr[DELAY-1];
    end

endmodule

// File: rtl/xvga_timing_gen.sv
// Free-running raster timing generator (default XVGA 1024x768@60, 65 MHz).
// Ports: vclock, reset_n (async low), o_vga master bundle of counts/syncs.
module xvga_timing_gen
    import xvga_pkg::*;
#(
    parameter int H_ACTIVE = XGA_H_ACTIVE,
    parameter int H_FP     = XGA_H_FP,
    parameter int H_SYNC   = XGA_H_SYNC,
    parameter int H_BP     = XGA_H_BP,
    parameter int V_ACTIVE = XGA_V_ACTIVE,
    parameter int V_FP     = XGA_V_FP,
    parameter int V_SYNC   = XGA_V_SYNC,
    parameter int V_BP     = XGA_V_BP,
    parameter int DELAY    = 0
) (
    input  logic               vclock,
    input  logic               reset_n,
    xvga_timing_gen_if.master  o_vga
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    if (!cnt_fits(H_TOTAL, HCNT_W)) begin : g_bad_h
        $error("xvga_timing_gen: H_TOTAL exceeds hcount width");
    end
    if (!cnt_fits(V_TOTAL, VCNT_W)) begin : g_bad_v
        $error("xvga_timing_gen: V_TOTAL exceeds vcount width");
    end

    localparam logic [HCNT_W-1:0] L_HMAX = HCNT_W'(H_TOTAL - 1);
    localparam logic [VCNT_W-1:0] L_VMAX = VCNT_W'(V_TOTAL - 1);

    // Decode thresholds kept at 32 bits so an end edge equal to
    // 2**width does not wrap to zero.
    localparam logic [31:0] C_HACT = 32'(H_ACTIVE);
    localparam logic [31:0] C_VACT = 32'(V_ACTIVE);
    localparam logic [31:0] C_HS0  = 32'(HS_START);
    localparam logic [31:0] C_HS1  = 32'(HS_END);
    localparam logic [31:0] C_VS0  = 32'(VS_START);
    localparam logic [31:0] C_VS1  = 32'(VS_END);

    logic [HCNT_W-1:0] r_hcount;
    logic [VCNT_W-1:0] r_vcount;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_blank;
    logic              r_line_start;
    logic              r_frame_start;

    logic              w_hwrap;
    logic [HCNT_W-1:0] w_hnxt;
    logic [VCNT_W-1:0] w_vnxt;
    logic [31:0]       w_h32;
    logic [31:0]       w_v32;
    logic              w_hsync_nxt;
    logic              w_vsync_nxt;
    logic              w_blank_nxt;
    logic [2:0]        w_dly;

    assign w_hwrap = (r_hcount == L_HMAX);
    assign w_hnxt  = w_hwrap ? '0 : r_hcount + HCNT_W'(1);

    always_comb begin
        w_vnxt = r_vcount;
        if (w_hwrap) begin
            w_vnxt = (r_vcount == L_VMAX) ? '0
                                          : r_vcount + VCNT_W'(1);
        end
    end

    // Flags decode the next counter values so that, once registered,
    // they describe the same pixel as the registered counters.
    assign w_h32       = 32'(w_hnxt);
    assign w_v32       = 32'(w_vnxt);
    assign w_hsync_nxt = !((w_h32 >= C_HS0) && (w_h32 < C_HS1));
    assign w_vsync_nxt = !((w_v32 >= C_VS0) && (w_v32 < C_VS1));
    assign w_blank_nxt = (w_h32 >= C_HACT) || (w_v32 >= C_VACT);

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_blank       <= 1'b0;
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b1;
        end else begin
            r_hcount      <= w_hnxt;
            r_vcount      <= w_vnxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_blank       <= w_blank_nxt;
            r_line_start  <= (w_hnxt == '0);
            r_frame_start <= (w_hnxt == '0) && (w_vnxt == '0);
        end
    end

    sync_delay_line #(
        .W       (3),
        .DELAY   (DELAY),
        .RST_VAL (3'b110)
    ) u_dly (
        .clk   (vclock),
        .rst_n (reset_n),
        .i_d   ({r_hsync, r_vsync, r_blank}),
        .o_q   (w_dly)
    );

    assign o_vga.hcount      = r_hcount;
    assign o_vga.vcount      = r_vcount;
    assign o_vga.hsync       = r_hsync;
    assign o_vga.vsync       = r_vsync;
    assign o_vga.blank       = r_blank;
    assign o_vga.line_start  = r_line_start;
    assign o_vga.frame_start = r_frame_start;
    assign o_vga.dhsync      = w_dly[2];
    assign o_vga.dvsync      = w_dly[1];
    assign o_vga.dblank      = w_dly[0];

endmodule

// File: tb/tb_xvga_timing_gen.sv
// Directed bench: full-size XVGA instance plus a shrunken-raster instance.
// The small one (24x13 totals, DELAY=3) exercises frame-level behaviour.
module tb_xvga_timing_gen;
    import xvga_pkg::*;

    logic vclock = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 vclock = ~vclock;

    xvga_timing_gen_if if0 ();
    xvga_timing_gen_if ifs ();

    xvga_timing_gen u0 (
        .vclock  (vclock),
        .reset_n (rst_n),
        .o_vga   (if0)
    );

    // Small raster: H 16+2+3+3=24, V 8+1+2+2=13, frame = 312 clocks.
    xvga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (2),
        .DELAY    (3)
    ) us (
        .vclock  (vclock),
        .reset_n (rst_n),
        .o_vga   (ifs)
    );

    function automatic logic [7:0] flags0();
        return {if0.hsync, if0.vsync, if0.blank,
                if0.line_start, if0.frame_start,
                if0.dhsync, if0.dvsync, if0.dblank};
    endfunction

    function automatic logic [7:0] flagss();
        return {ifs.hsync, ifs.vsync, ifs.blank,
                ifs.line_start, ifs.frame_start,
                ifs.dhsync, ifs.dvsync, ifs.dblank};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge vclock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge vclock);
        checks++;
        if ({if0.hcount, if0.vcount} !== 21'd0) begin
            errors++;
            $display("FAIL rst_cnt: got h=%0d v=%0d want 0/0",
                     if0.hcount, if0.vcount);
        end
        checks++;
        if (flags0() !== 8'b1101_1110) begin
            errors++;
            $display("FAIL rst_flags: got %b want 11011110", flags0());
        end
        checks++;
        if (flagss() !== 8'b1101_1110) begin
            errors++;
            $display("FAIL rst_flags_s: got %b want 11011110", flagss());
        end
        rst_n = 1'b1;
        cyc   = 0;
        tick(1);
        checks++;
        if ({if0.hcount, if0.vcount} !== {11'd1, 10'd0}) begin
            errors++;
            $display("FAIL post_cnt: got h=%0d v=%0d want 1/0",
                     if0.hcount, if0.vcount);
        end
        checks++;
        if (flags0() !== 8'b1100_0110) begin
            errors++;
            $display("FAIL post_flags: got %b want 11000110", flags0());
        end
    endtask

    task automatic test_line();
        int         pc [9] = '{1023, 1024, 1047, 1048, 1183,
                               1184, 1343, 1344, 1345};
        int         ph [9] = '{1023, 1024, 1047, 1048, 1183,
                               1184, 1343, 0, 1};
        int         pv [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
        logic [7:0] pf [9] = '{8'b1100_0110, 8'b1110_0111,
                               8'b1110_0111, 8'b0110_0011,
                               8'b0110_0011, 8'b1110_0111,
                               8'b1110_0111, 8'b1101_0110,
                               8'b1100_0110};
        for (int i = 0; i < 9; i++) begin
            tick(pc[i] - cyc);
            checks++;
            if ({if0.hcount, if0.vcount} !==
                {11'(ph[i]), 10'(pv[i])}) begin
                errors++;
                $display("FAIL line_cnt[%0d]: got h=%0d v=%0d want %0d/%0d",
                         i, if0.hcount, if0.vcount, ph[i], pv[i]);
            end
            checks++;
            if (flags0() !== pf[i]) begin
                errors++;
                $display("FAIL line_flags[%0d]: got %b want %b",
                         i, flags0(), pf[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1844 - cyc);
        checks++;
        if ({if0.hcount, if0.vcount} !== {11'd500, 10'd1}) begin
            errors++;
            $display("FAIL pre_arst: got h=%0d v=%0d want 500/1",
                     if0.hcount, if0.vcount);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if0.hcount, if0.vcount} !== 21'd0) begin
            errors++;
            $display("FAIL arst_cnt: got h=%0d v=%0d want 0/0",
                     if0.hcount, if0.vcount);
        end
        checks++;
        if (flags0() !== 8'b1101_1110) begin
            errors++;
            $display("FAIL arst_flags: got %b want 11011110", flags0());
        end
        checks++;
        if (flagss() !== 8'b1101_1110 || ifs.hcount !== 11'd0) begin
            errors++;
            $display("FAIL arst_small: got %b h=%0d want 11011110 h=0",
                     flagss(), ifs.hcount);
        end
        @(negedge vclock);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_model_3frames();
        logic [2:0]  hq [$] = '{3'b110, 3'b110, 3'b110};
        logic [28:0] exp_v;
        logic [28:0] act_v;
        logic        hs, vs, bl, ls, fs;
        int          h, v;
        for (int k = 0; k < 3 * 312; k++) begin
            tick(1);
            h  = cyc % 24;
            v  = (cyc / 24) % 13;
            hs = !(h >= 18 && h < 21);
            vs = !(v >= 9 && v < 11);
            bl = (h >= 16) || (v >= 8);
            ls = (h == 0);
            fs = (h == 0) && (v == 0);
            exp_v = {11'(h), 10'(v), hs, vs, bl, ls, fs, hq[0]};
            act_v = {ifs.hcount, ifs.vcount, ifs.hsync, ifs.vsync,
                     ifs.blank, ifs.line_start, ifs.frame_start,
                     ifs.dhsync, ifs.dvsync, ifs.dblank};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model c=%0d: got %h want %h",
                         cyc, act_v, exp_v);
            end
            void'(hq.pop_front());
            hq.push_back({hs, vs, bl});
        end
    endtask

    task automatic test_frame_period();
        int                n  = 0;
        logic [HCNT_W-1:0] ph = '0;
        logic [VCNT_W-1:0] pv = '0;
        do begin
            ph = ifs.hcount;
            pv = ifs.vcount;
            tick(1);
            n++;
        end while (ifs.frame_start !== 1'b1 && n < 400);
        checks++;
        if (n != 312) begin
            errors++;
            $display("FAIL frame_period: got %0d want 312", n);
        end
        checks++;
        if ({ph, pv} !== {11'd23, 10'd12} ||
            {ifs.hcount, ifs.vcount} !== 21'd0) begin
            errors++;
            $display("FAIL frame_wrap: got %0d/%0d->%0d/%0d want 23/12->0/0",
                     ph, pv, ifs.hcount, ifs.vcount);
        end
    endtask

    task automatic test_free_run();
        int         h = cyc % 1344;
        int         v = (cyc / 1344) % 806;
        logic       hs = !(h >= 1048 && h < 1184);
        logic       bl = (h >= 1024) || (v >= 768);
        logic [7:0] ef = {hs, 1'b1, bl, h == 0, h == 0 && v == 0,
                          hs, 1'b1, bl};
        checks++;
        if ({if0.hcount, if0.vcount} !== {11'(h), 10'(v)}) begin
            errors++;
            $display("FAIL free_cnt: got h=%0d v=%0d want %0d/%0d",
                     if0.hcount, if0.vcount, h, v);
        end
        checks++;
        if (flags0() !== ef) begin
            errors++;
            $display("FAIL free_flags: got %b want %b", flags0(), ef);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line();
        test_async_reset();
        test_model_3frames();
        test_frame_period();
        test_free_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xvga_timing_gen.md
Name: xvga_timing_gen

Overview:
Generates XVGA 1024x768@60 Hz raster timing from the 65 MHz pixel clock. It drives the hcount, vcount, hsync, vsync and blank signals consumed by every pixel generator in the display path. It also provides frame and line start strobes. A configurable delay line supplies sync/blank copies aligned to pixel generators with pipeline latency.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (clocks)
H_SYNC, 136, horizontal sync width (clocks)
H_BP, 160, horizontal back porch (clocks); H_TOTAL = 1344
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines); V_TOTAL = 806
DELAY, 0, extra cycles of delay on dhsync/dvsync/dblank (0..15)

Ports:
vclock  input  1  65 MHz pixel clock
reset_n  input  1  asynchronous, active-low reset
hcount  output  11  horizontal pixel index, 0..H_TOTAL-1
vcount  output  10  vertical line index, 0..V_TOTAL-1
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
blank  output  1  1 outside the active 1024x768 area
line_start  output  1  one-cycle pulse when hcount==0
frame_start  output  1  one-cycle pulse when hcount==0 and vcount==0
dhsync  output  1  hsync delayed DELAY cycles
dvsync  output  1  vsync delayed DELAY cycles
dblank  output  1  blank delayed DELAY cycles

Behaviour:
- All outputs are registered.
- hcount, vcount, hsync, vsync, blank, line_start and frame_start describe the same pixel in the same cycle. Zero skew between them.
- Reset (reset_n low, async assert, sync release on vclock):
  - hcount=0, vcount=0.
  - hsync=1, vsync=1, blank=0.
  - line_start=1, frame_start=1, since the counters sit at (0,0).
  - Delay-line stages all reset to hsync=1, vsync=1, blank=0.
- Horizontal counter:
  - hcount increments every vclock.
  - At hcount==H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - vcount increments only on the hcount wrap.
  - At vcount==V_TOTAL-1 together with the hcount wrap, it wraps to 0.
- Decode is computed from the next-state counter values, so registered flags align with registered counters:
  - hblank = hcount >= H_ACTIVE.
  - vblank = vcount >= V_ACTIVE.
  - blank = hblank | vblank.
  - hsync = 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 1048..1183.
  - vsync = 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 771..776. It spans whole lines and switches at hcount==0.
- No states beyond the two counters. No handshake; the generator is free-running.
- Delay line: a DELAY-deep shift register of {hsync,vsync,blank}.
  - DELAY=0: dhsync/dvsync/dblank equal hsync/vsync/blank combinationally from the registers, with no extra cycle.
- Reset mid-frame: counters return to (0,0) immediately (async) and the frame restarts. The first post-release cycle shows hcount=1.
- Counter widths: 11 bits covers 1343 and 10 bits covers 805. Parameter sets whose totals overflow these widths are unsupported and must be rejected by an elaboration-time check.

Decomposition:
- Shared package xvga_pkg holds:
  - the eight timing constants and derived H_TOTAL/V_TOTAL;
  - HSYNC_START/HSYNC_END and VSYNC_START/VSYNC_END;
  - count-width constants.
- One sub-module: sync_delay_line. It is a parameterized-width, DELAY-deep shift register with async active-low reset and a per-bit reset value. Pixel generators reuse it to re-align their own sync/blank outputs.

Test Plan:
- Reset, then release → first cycle hcount=1, vcount=0, hsync=1, vsync=1, blank=0. frame_start was high during reset and is low now.
- Run one line → blank rises at hcount=1024. hsync falls at hcount=1048 and rises at 1184. hcount goes 1343→0 with vcount 0→1 and line_start=1 for one cycle.
- Run one full frame → vsync low exactly for vcount 771..776. blank=1 for all of vcount 768..805. vcount goes 805→0 at hcount wrap with frame_start=1. Frame period is exactly 1344*806=1,083,264 cycles.
- DELAY=3 build → dhsync/dvsync/dblank equal hsync/vsync/blank shifted by exactly 3 cycles across the hsync fall at hcount 1048 and the frame wrap.
- Assert reset_n low asynchronously mid-line at hcount=500, vcount=400 → outputs go to reset values without waiting for a clock edge. After release, the next frame is full length with correct sync positions.
- Run 3 frames → every cycle, a reference model comparator checks all outputs for each pixel, and finds zero mismatches.
